// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory.
// Core has priority, loader starvation bounded; read valids are routed to the issuer.
//
// Ports:
//   clk, reset      : clock, async active-low reset (0 = in reset)
//   cpu_*           : core request/grant/read-return channel
//   ldr_*           : loader/debug request/grant/read-return channel
//   ldr_excl        : loader-only mode, core receives no grants
//   mem_*           : single-port memory strobe, write, address, data
//   starved         : starvation override active this cycle
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,

  input  logic          ldr_excl,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          starved
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       at_limit;
  logic       gnt_we;

  assign at_limit = (starve_cnt == LIM);

  // Grants are combinational; reset gates them so nothing
  // reaches the memory while the block is held in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    starved = 1'b0;
    if (!reset) begin
      cpu_gnt = 1'b0;
    end else if (ldr_excl) begin
      ldr_gnt = ldr_req;
    end else if (ldr_req && at_limit) begin
      ldr_gnt = 1'b1;
      starved = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (ldr_req) begin
      ldr_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | ldr_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign gnt_we = mem_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (ldr_gnt || !ldr_req) begin
        starve_cnt <= 4'd0;
      end else if (cpu_gnt && !at_limit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      // Owner is captured only on a read grant; the return
      // lands next cycle regardless of any new grant.
      if (mem_en && !gnt_we) begin
        rd_pend  <= 1'b1;
        rd_owner <= ldr_gnt;
      end else begin
        rd_pend  <= 1'b0;
      end
    end
  end

  assign cpu_rvalid = rd_pend & ~rd_owner;
  assign ldr_rvalid = rd_pend &  rd_owner;
  assign cpu_rdata  = mem_rdata;
  assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Scoreboard of read returns plus per-cycle grant/memory checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        ldr_excl;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        starved;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] tbmem  [0:255];
  logic [31:0] ref_mem[0:255];
  logic [32:0] q[$];

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .ldr_rdata(ldr_rdata),
    .ldr_excl(ldr_excl),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .starved(starved)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Memory model: capture the strobe mid-cycle, act on the edge.
  task automatic mem_model();
    logic        en, we;
    logic [31:0] a, d;
    forever begin
      @(negedge clk);
      en = mem_en; we = mem_we;
      a  = mem_addr; d = mem_wdata;
      @(posedge clk);
      if (en) begin
        if (we) tbmem[a[9:2]] = d;
        else    mem_rdata = tbmem[a[9:2]];
      end
    end
  endtask

  // One cycle: check returns, grants and memory drive, then
  // record expected read returns / writes from the driven stimulus.
  task automatic step(input logic ecg,
                      input logic elg,
                      input logic est);
    logic        ew;
    logic [31:0] ea, ed;
    logic [32:0] e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(!e[32]));
      chk("ldr_rvalid", 64'(ldr_rvalid), 64'(e[32]));
      chk("rdata", 64'(e[32] ? ldr_rdata : cpu_rdata),
          64'(e[31:0]));
    end else begin
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      chk("ldr_rvalid", 64'(ldr_rvalid), 64'(0));
    end
    chk("cpu_gnt", 64'(cpu_gnt), 64'(ecg));
    chk("ldr_gnt", 64'(ldr_gnt), 64'(elg));
    chk("starved", 64'(starved), 64'(est));
    ew = 1'b0; ea = '0; ed = '0;
    if (ecg) begin
      ew = cpu_we; ea = cpu_addr; ed = cpu_wdata;
    end else if (elg) begin
      ew = ldr_we; ea = ldr_addr; ed = ldr_wdata;
    end
    chk("mem_en", 64'(mem_en), 64'(ecg | elg));
    chk("mem_we", 64'(mem_we), 64'(ew));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wdata", 64'(mem_wdata), 64'(ed));
    if (ecg || elg) begin
      if (ew) ref_mem[ea[9:2]] = ed;
      else    q.push_back({elg, ref_mem[ea[9:2]]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic r, input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ldr_drive(input logic r, input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d);
    ldr_req = r; ldr_we = w; ldr_addr = a; ldr_wdata = d;
  endtask

  initial begin
    reset = 1'b0;
    ldr_excl = 1'b0;
    mem_rdata = '0;
    cpu_drive(0, 0, 0, 0);
    ldr_drive(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      tbmem[i]   = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    tbmem[4]   = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    fork
      mem_model();
    join_none

    // Reset: requests present, nothing granted.
    cpu_drive(1, 0, 32'h10, 0);
    step(0, 0, 0);
    chk("rst_cnt", 64'(dut.starve_cnt), 64'(0));

    // Release with request held: granted in release cycle.
    reset = 1'b1;
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    step(0, 0, 0);

    // Both requesting: 4 core grants then starved loader.
    cpu_drive(1, 0, 32'h40, 0);
    ldr_drive(1, 0, 32'h80, 0);
    for (int i = 0; i < 10; i++)
      step(i % 5 != 4, i % 5 == 4, i % 5 == 4);
    cpu_drive(0, 0, 0, 0);
    ldr_drive(0, 0, 0, 0);
    step(0, 0, 0);

    // Alternating owners on consecutive reads.
    cpu_drive(1, 0, 32'h0, 0);
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    ldr_drive(1, 0, 32'h4, 0);
    step(0, 1, 0);
    ldr_drive(0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Exclusive loader writes; core blocked.
    ldr_excl = 1'b1;
    cpu_drive(1, 1, 32'h200, 32'hFFFF_0000);
    for (int i = 0; i < 8; i++) begin
      ldr_drive(1, 1, 32'h100 + 32'(4 * i),
                32'hC0DE_0000 + 32'(i));
      step(0, 1, 0);
    end
    ldr_excl = 1'b0;
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    ldr_drive(1, 0, 32'h10C, 0);
    step(0, 1, 0);
    ldr_drive(1, 0, 32'h200, 0);
    step(0, 1, 0);
    ldr_drive(0, 0, 0, 0);
    step(0, 0, 0);

    // Exclusive raised while a core read is pending.
    cpu_drive(1, 0, 32'h40, 0);
    step(1, 0, 0);
    ldr_excl = 1'b1;
    step(0, 0, 0);
    ldr_excl = 1'b0;
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    step(0, 0, 0);

    // Reset right after a read grant drops the return.
    cpu_drive(1, 0, 32'h10, 0);
    ldr_drive(1, 0, 32'h80, 0);
    step(1, 0, 0);
    chk("cnt_pre", 64'(dut.starve_cnt), 64'(1));
    reset = 1'b0;
    q.delete();
    cpu_drive(0, 0, 0, 0);
    step(0, 0, 0);
    chk("rst_cnt2", 64'(dut.starve_cnt), 64'(0));
    ldr_drive(0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // Core write, no return; then read it back.
    cpu_drive(1, 1, 32'h20, 32'h1234_5678);
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    step(0, 0, 0);
    cpu_drive(1, 0, 32'h20, 0);
    step(1, 0, 0);
    cpu_drive(0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    chk("q_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port unified instruction/data memory used by the multicycle RISC-V core. Requester 0 is the core's memory interface, which carries fetches at `AdrSrc=0` and loads/stores at `AdrSrc=1`. Requester 1 is the program loader/debug port. The block grants one access per cycle, gives the core priority, and bounds loader starvation with a counter. It also routes read-return valids back to whichever requester issued the read.

## Interface
- `AW`, 32: address width (byte address).
- `DW`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive core grants tolerated while the loader waits (1..15).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `cpu_req`  in  1  core access request; held with fields stable until `cpu_gnt`.
- `cpu_we`  in  1  core write enable.
- `cpu_addr`  in  AW  core address.
- `cpu_wdata`  in  DW  core write data.
- `cpu_gnt`  out  1  core access accepted this cycle.
- `cpu_rvalid`  out  1  core read data valid.
- `cpu_rdata`  out  DW  core read data.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: loader equivalents, same widths and directions.
- `ldr_excl`  in  1  exclusive loader mode; core receives no grants.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid the cycle after a read strobe.
- `starved`  out  1  starvation override active this cycle (debug/observability).

## Operation
- Handshake:
  - Requester asserts `*_req` with `*_we`, `*_addr` and `*_wdata` stable.
  - Transfer occurs in the cycle where `*_req & *_gnt` is sampled at the rising edge.
  - Requester may drop or change `req` only after that edge.
- Grants are combinational from current requests and registered state. At most one of `cpu_gnt`/`ldr_gnt` is high in any cycle.
- Arbitration per cycle, first match wins:
  - `reset`=0: no grant.
  - `ldr_excl`=1: `ldr_gnt = ldr_req`, `cpu_gnt = 0`.
  - `ldr_req & starve_cnt == STARVE_LIMIT`: loader wins and `starved = 1`.
  - `cpu_req`: core wins.
  - `ldr_req`: loader wins.
- Memory drive:
  - `mem_en = cpu_gnt | ldr_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted requester.
  - With no grant, the memory outputs are all 0.
- `starve_cnt` (4-bit register) updates each cycle:
  - cleared if `ldr_gnt` or `!ldr_req`;
  - otherwise incremented if `cpu_gnt & ldr_req`, saturating at `STARVE_LIMIT`;
  - otherwise held.
- Read return:
  - A granted read (`we = 0`) sets `rd_pend <= 1` and `rd_owner <=` the granted requester.
  - The next cycle, the owner's `rvalid = 1`. Otherwise `rd_pend <= 0`.
  - Writes never produce `rvalid`.
- `cpu_rdata` and `ldr_rdata` both pass `mem_rdata` combinationally; they are meaningful only while the matching `rvalid` is high.
- Back-to-back reads are allowed. A return for grant N coincides with grant N+1, and the owner can differ between consecutive cycles.
- Address and data are passed unchanged. There is no alignment check; `mem_addr` width is `AW`.

## Timing
- Reset (`reset`=0, asynchronous): `starve_cnt = 0`, `rd_pend = 0`, `rd_owner = 0`. All grants, `rvalid`, `mem_en`, `mem_we` and `starved` are 0 while asserted.
- Grant latency: 0 cycles, so a lone request is granted in the cycle it is raised.
- Read latency: `rvalid` is asserted exactly 1 cycle after the granting edge, for exactly 1 cycle.
- Worst-case loader wait, outside `ldr_excl`: `STARVE_LIMIT + 1` cycles.
- Core wait under `ldr_excl`: unbounded. The core controller must hold `req` and stall in FETCH/MEMREAD/MEMWRITE until granted.
- Simultaneous read grant and pending return: both happen in the same cycle. The return goes to `rd_owner`, independent of the new grant.
- `ldr_excl` rising while a core read is pending: the pending `cpu_rvalid` still fires next cycle. Only new grants are blocked.
- Reset asserted mid-read: the pending `rvalid` is discarded, and no `rvalid` appears after reset release.
- Reset released: the first grant is possible in the same cycle as the release, provided `req` is present.

## Test plan
- Lone core read of `cpu_addr=0x10`, `mem_rdata=0xDEADBEEF` -> `cpu_gnt`, `mem_en=1`, `mem_we=0`, `mem_addr=0x10` in cycle 0; `cpu_rvalid=1` and `cpu_rdata=0xDEADBEEF` in cycle 1; `ldr_rvalid=0` throughout.
- Both requesting continuously, `STARVE_LIMIT=4` -> core granted for 4 cycles, then loader granted with `starved=1` in cycle 4, then core resumes. The pattern repeats every 5 cycles.
- Alternating reads, core at `0x0` then loader at `0x4` on consecutive cycles -> `cpu_rvalid` in cycle 1 and `ldr_rvalid` in cycle 2; each `rvalid` lasts one cycle and goes to the correct owner.
- `ldr_excl=1`, core and loader both requesting writes for 8 cycles -> 8 loader writes with `mem_we=1`, `cpu_gnt=0` throughout. Deasserting `ldr_excl` gives `cpu_gnt` in the same cycle.
- Core read granted, then `reset=0` for 1 cycle immediately after the edge -> no `cpu_rvalid`, all outputs 0 during reset, `starve_cnt` back to 0.
- Core write of `0x12345678` to `0x20` -> `mem_we=1`, `mem_wdata=0x12345678`, and no `rvalid` in the following cycle.
